// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   - hazard_state_e : controller FSM state (run / multiply wait)
//   - clog2          : ceiling log2, used to size internal counters
//   - Def*           : default parameter values for hazard_ctrl_unit
package hazard_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMulWait = 1'b1
  } hazard_state_e;

  localparam int unsigned DefRegAw     = 5;
  localparam int unsigned DefMulLat    = 4;
  localparam int unsigned DefMemTimeout = 256;
  localparam int unsigned DefCntW      = 32;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_lu_cmp.sv
// Load-use hazard comparator.
// Flags when the load in EX writes a register (other than x0) that the
// instruction in ID actually reads.
//   id_rs1_i/id_rs2_i         : ID-stage source registers
//   id_rs1_use_i/id_rs2_use_i : source operand is really read
//   ex_rd_i, ex_memread_i     : EX-stage destination and load flag
//   lu_hit_o                  : load-use hazard present
module hazard_lu_cmp #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  output logic              lu_hit_o
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = id_rs1_use_i & (id_rs1_i == ex_rd_i);
  assign w_rs2_match = id_rs2_use_i & (id_rs2_i == ex_rd_i);
  assign lu_hit_o    = ex_memread_i & (ex_rd_i != '0) & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Arbitrates memory wait, multi-cycle multiply hold, taken-branch flush and
// load-use bubbles; also runs a memory-wait watchdog and a stall counter.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   id_*/ex_rd/ex_memread : load-use detection inputs
//   ex_mul_i              : multiply in EX
//   ex_branch_taken_i     : branch resolved taken in EX
//   mem_req_i/mem_ready_i : data-memory request / acknowledge
//   pc_write_o, ifid_write_o, idex_noop_o, ifid_flush_o, pipe_hold_o : pipeline controls
//   mem_err_o             : sticky memory timeout
//   stall_cnt_o           : saturating count of cycles with pc_write_o low
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = DefRegAw,
  parameter int unsigned MUL_LAT     = DefMulLat,
  parameter int unsigned MEM_TIMEOUT = DefMemTimeout,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              ex_mul_i,
  input  logic              ex_branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_noop_o,
  output logic              ifid_flush_o,
  output logic              pipe_hold_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned MulCw    = (clog2(MUL_LAT) > 0) ? clog2(MUL_LAT) : 1;
  localparam int unsigned MulLoad  = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam bit          MulMulti = (MUL_LAT > 1);
  localparam int unsigned WdW      = (clog2(MEM_TIMEOUT + 1) > 0) ? clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(MEM_TIMEOUT - 1);

  hazard_state_e    r_state;
  hazard_state_e    w_state_d;
  logic [MulCw-1:0] r_mul_cnt;
  logic [MulCw-1:0] w_mul_cnt_d;
  logic [WdW-1:0]   r_wd_cnt;

  logic w_mem_stall;
  logic w_lu_hit;
  logic w_hold;

  hazard_lu_cmp #(
    .REG_AW (REG_AW)
  ) u_lu_cmp (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_use_i (id_rs1_use_i),
    .id_rs2_use_i (id_rs2_use_i),
    .ex_rd_i      (ex_rd_i),
    .ex_memread_i (ex_memread_i),
    .lu_hit_o     (w_lu_hit)
  );

  assign w_mem_stall = mem_req_i & ~mem_ready_i;

  // The first multiply cycle is held from RUN; MUL_WAIT covers the rest until
  // the counter drains. A memory stall in MUL_WAIT is already in w_mem_stall.
  assign w_hold = w_mem_stall
                | ((r_state == StRun) & ex_mul_i & MulMulti)
                | ((r_state == StMulWait) & (r_mul_cnt != '0));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= StRun;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_mul_cnt <= w_mul_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d   = r_state;
    w_mul_cnt_d = r_mul_cnt;
    unique case (r_state)
      StRun: begin
        if (ex_mul_i && !w_mem_stall && MulMulti) begin
          w_state_d   = StMulWait;
          w_mul_cnt_d = MulCw'(MulLoad);
        end
      end
      StMulWait: begin
        if (!w_mem_stall) begin
          if (r_mul_cnt != '0) begin
            w_mul_cnt_d = r_mul_cnt - 1'b1;
          end else begin
            w_state_d = StRun;
          end
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  // Output logic; reset forces a bubble with fetch frozen.
  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    idex_noop_o  = 1'b0;
    ifid_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    if (!rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_noop_o  = 1'b1;
    end else if (w_hold) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (ex_branch_taken_i) begin
      // Flushed ID instruction is squashed, so any load-use hit is irrelevant.
      ifid_flush_o = 1'b1;
      idex_noop_o  = 1'b1;
    end else if (w_lu_hit) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_noop_o  = 1'b1;
    end
  end

  // Memory-wait watchdog; the count saturates so mem_err_o stays meaningful.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wd_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else if (w_mem_stall) begin
      if (r_wd_cnt <= WdLast) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (r_wd_cnt >= WdLast) begin
        mem_err_o <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (!pc_write_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  // Control vector order: {pc_write, ifid_write, idex_noop, ifid_flush, pipe_hold}
  localparam logic [4:0] CNorm = 5'b11000;
  localparam logic [4:0] CHold = 5'b00001;
  localparam logic [4:0] CBr   = 5'b11110;
  localparam logic [4:0] CLu   = 5'b00100;
  localparam logic [4:0] CRst  = 5'b00100;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              rs1_use, rs2_use, ex_memread, ex_mul, br_taken, mem_req, mem_ready;
  logic              pc_write, ifid_write, idex_noop, ifid_flush, pipe_hold, mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [4:0]        ctl;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned exp_stall;
  logic        exp_err;

  hazard_ctrl_unit #(
    .REG_AW      (REG_AW),
    .MUL_LAT     (4),
    .MEM_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_rs1_use_i      (rs1_use),
    .id_rs2_use_i      (rs2_use),
    .ex_rd_i           (ex_rd),
    .ex_memread_i      (ex_memread),
    .ex_mul_i          (ex_mul),
    .ex_branch_taken_i (br_taken),
    .mem_req_i         (mem_req),
    .mem_ready_i       (mem_ready),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .idex_noop_o       (idex_noop),
    .ifid_flush_o      (ifid_flush),
    .pipe_hold_o       (pipe_hold),
    .mem_err_o         (mem_err),
    .stall_cnt_o       (stall_cnt)
  );

  assign ctl = {pc_write, ifid_write, idex_noop, ifid_flush, pipe_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; rs1_use = 1'b0; rs2_use = 1'b0;
    ex_rd = '0; ex_memread = 1'b0; ex_mul = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Check one cycle mid-period, then advance; the stall model counts expected
  // cycles with pc_write low.
  task automatic cyc(input string tag, input logic [4:0] exp_ctl);
    @(negedge clk);
    check($sformatf("%s/ctl", tag), 32'(ctl), 32'(exp_ctl));
    check($sformatf("%s/stall", tag), stall_cnt, exp_stall);
    check($sformatf("%s/err", tag), 32'(mem_err), 32'(exp_err));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_stall = 0;
      exp_err   = 1'b0;
    end else if (!exp_ctl[4]) begin
      exp_stall++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_stall = 0; exp_err = 1'b0;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst0", CRst);
    cyc("rst1", CRst);
    rst_n = 1'b1;
    cyc("idle", CNorm);

    // Load-use on rs2, then the bubble has moved on.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; rs2_use = 1'b1;
    cyc("lu_rs2", CLu);
    idle();
    cyc("lu_after", CNorm);
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; rs2_use = 1'b1;
    cyc("lu_x0", CNorm);
    ex_rd = 5'd5; id_rs2 = 5'd5; rs2_use = 1'b0;
    cyc("lu_nouse", CNorm);
    id_rs1 = 5'd5; rs1_use = 1'b1;
    cyc("lu_rs1", CLu);
    idle();

    // MUL_LAT=4: three held cycles, released on the fourth.
    ex_mul = 1'b1;
    cyc("mul1", CHold);
    cyc("mul2", CHold);
    cyc("mul3", CHold);
    cyc("mul4", CNorm);
    ex_mul = 1'b0;
    cyc("mul_done", CNorm);

    // Memory stall while mul_cnt=1 freezes the counter.
    ex_mul = 1'b1;
    cyc("mm1", CHold);
    cyc("mm2", CHold);
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("mm_stall%0d", i), CHold);
    mem_ready = 1'b1;
    cyc("mm_extra", CHold);
    cyc("mm_rel", CNorm);
    idle();

    // Branch beats load-use; branch under memory stall is deferred.
    br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; rs1_use = 1'b1;
    cyc("br_lu", CBr);
    idle();
    br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    cyc("br_mem", CHold);
    mem_ready = 1'b1;
    cyc("br_rel", CBr);
    idle();

    // Watchdog: 8 consecutive stall cycles raise a sticky error.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc($sformatf("wd%0d", i), CHold);
    exp_err = 1'b1;
    mem_ready = 1'b1;
    cyc("wd_ready", CNorm);
    idle();
    cyc("wd_sticky", CNorm);

    // Reset during MUL_WAIT aborts to RUN and clears counters.
    ex_mul = 1'b1;
    cyc("rmul1", CHold);
    rst_n = 1'b0;
    cyc("rmul_rst", CRst);
    rst_n = 1'b1;
    ex_mul = 1'b0;
    cyc("rmul_after", CNorm);
    ex_mul = 1'b1;
    cyc("rmul_new", CHold);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
